// File: rtl/nm_row_compressor_if.sv
// Row handshake bundle for nm_row_compressor: dense row in, 2:4 compressed row out.
// Defining NM_DROP_STATS_EN adds the drop_cnt signal to the bundle.
interface nm_row_compressor_if #(
   parameter int unsigned COLS = 64,
   parameter int unsigned BW   = 8,
   parameter int unsigned ROWS = 16,
   parameter int unsigned REGS = 8
);
   localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned GW = (REGS > 1) ? $clog2(REGS) : 1;

   logic                   in_valid;
   logic                   in_ready;
   logic [COLS*BW-1:0]     in_row;
   logic                   out_valid;
   logic                   out_ready;
   logic [COLS/2*BW-1:0]   out_val;
   logic [COLS/2*2-1:0]    out_meta;
   logic [RW-1:0]          out_row;
   logic [GW-1:0]          out_reg;
   logic                   out_last;

`ifdef NM_DROP_STATS_EN
   logic [5:0]             drop_cnt;

   modport master (
      output in_valid, in_row, out_ready,
      input  in_ready, out_valid, out_val, out_meta, out_row, out_reg, out_last, drop_cnt
   );
   modport slave (
      input  in_valid, in_row, out_ready,
      output in_ready, out_valid, out_val, out_meta, out_row, out_reg, out_last, drop_cnt
   );
`else
   modport master (
      output in_valid, in_row, out_ready,
      input  in_ready, out_valid, out_val, out_meta, out_row, out_reg, out_last
   );
   modport slave (
      input  in_valid, in_row, out_ready,
      output in_ready, out_valid, out_val, out_meta, out_row, out_reg, out_last
   );
`endif
endinterface

// File: rtl/nm_row_compressor.sv
// Dense-to-2:4-sparse row encoder: keeps the 2 largest-magnitude bytes of each group of 4.
// Optional NM_DROP_STATS_EN counts nonzero elements discarded per output row (drop_cnt).
module nm_row_compressor #(
   parameter int unsigned COLS = 64,
   parameter int unsigned BW   = 8,
   parameter int unsigned ROWS = 16,
   parameter int unsigned REGS = 8,
   parameter int unsigned GPC  = 4
) (
   input  logic                clk,
   input  logic                rst,
   nm_row_compressor_if.slave  bus
);
   localparam int unsigned NGRP   = COLS / 4;
   localparam int unsigned NCHUNK = NGRP / GPC;
   localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int unsigned RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned GW     = (REGS > 1) ? $clog2(REGS) : 1;

   typedef enum logic [1:0] {IDLE, COMPRESS, OUT} state_t;

   typedef struct packed {
      logic [2*BW-1:0] val;
      logic [3:0]      meta;
      logic [1:0]      drops;
   } enc_t;

   state_t               state;
   logic [CW-1:0]        chunk;
   logic [COLS*BW-1:0]   row_buf;
   logic                 ready_q;
   logic                 valid_q;
   logic [COLS/2*BW-1:0] val_q;
   logic [COLS/2*2-1:0]  meta_q;
   logic [RW-1:0]        dst_row;
   logic [GW-1:0]        dst_reg;
   logic                 last_q;
   int unsigned          gbase;
   enc_t                 enc [GPC];

   // An element survives when fewer than two others beat it (larger magnitude,
   // or equal magnitude at a lower index); this yields exactly two survivors.
   function automatic enc_t encode_group(input logic [4*BW-1:0] grp);
      enc_t        r;
      logic [BW:0] mag [4];
      logic [BW-1:0] x;
      int unsigned beats;
      logic        found;
      r     = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         x      = grp[i*BW +: BW];
         mag[i] = x[BW-1] ? ({1'b0, ~x} + (BW+1)'(1)) : {1'b0, x};
      end
      for (int unsigned i = 0; i < 4; i++) begin
         beats = 0;
         for (int unsigned j = 0; j < 4; j++) begin
            if (j != i && (mag[j] > mag[i] || (mag[j] == mag[i] && j < i)))
               beats++;
         end
         x = grp[i*BW +: BW];
         if (beats < 2) begin
            if (!found) begin
               r.val[BW-1:0] = x;
               r.meta[1:0]   = 2'(i);
               found         = 1'b1;
            end else begin
               r.val[2*BW-1:BW] = x;
               r.meta[3:2]      = 2'(i);
            end
         end else if (x != '0) begin
            r.drops = r.drops + 2'd1;
         end
      end
      return r;
   endfunction

   always_comb begin
      gbase = {{(32-CW){1'b0}}, chunk} * GPC;
      for (int unsigned j = 0; j < GPC; j++)
         enc[j] = encode_group(row_buf[(gbase+j)*4*BW +: 4*BW]);
   end

`ifdef NM_DROP_STATS_EN
   logic [5:0] drop_q;
   logic [5:0] chunk_drops;

   always_comb begin
      chunk_drops = '0;
      for (int unsigned j = 0; j < GPC; j++)
         chunk_drops = chunk_drops + 6'(enc[j].drops);
   end

   always_ff @(posedge clk) begin
      if (rst)
         drop_q <= '0;
      else if (state == IDLE && bus.in_valid && ready_q)
         drop_q <= '0;
      else if (state == COMPRESS)
         drop_q <= drop_q + chunk_drops;
   end

   assign bus.drop_cnt = drop_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         chunk   <= '0;
         row_buf <= '0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         val_q   <= '0;
         meta_q  <= '0;
         dst_row <= '0;
         dst_reg <= '0;
         last_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ready_q <= 1'b1;
               if (bus.in_valid && ready_q) begin
                  row_buf <= bus.in_row;
                  chunk   <= '0;
                  ready_q <= 1'b0;
                  state   <= COMPRESS;
               end
            end
            COMPRESS: begin
               for (int unsigned j = 0; j < GPC; j++) begin
                  val_q[(gbase+j)*2*BW +: 2*BW] <= enc[j].val;
                  meta_q[(gbase+j)*4 +: 4]      <= enc[j].meta;
               end
               if (chunk == CW'(NCHUNK-1)) begin
                  valid_q <= 1'b1;
                  state   <= OUT;
               end else begin
                  chunk <= chunk + 1'b1;
               end
            end
            OUT: begin
               if (bus.out_ready) begin
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  state   <= IDLE;
                  if (dst_row == RW'(ROWS-1)) begin
                     dst_row <= '0;
                     last_q  <= 1'b0;
                     dst_reg <= (dst_reg == GW'(REGS-1)) ? '0 : dst_reg + 1'b1;
                  end else begin
                     dst_row <= dst_row + 1'b1;
                     last_q  <= (dst_row == RW'(ROWS-2));
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = ready_q;
   assign bus.out_valid = valid_q;
   assign bus.out_val   = val_q;
   assign bus.out_meta  = meta_q;
   assign bus.out_row   = dst_row;
   assign bus.out_reg   = dst_reg;
   assign bus.out_last  = last_q;
endmodule

// File: tb/tb_nm_row_compressor.sv
// Directed bench for nm_row_compressor: encoding patterns, latency, backpressure,
// address wrap and mid-compress reset, with drop_cnt checks when NM_DROP_STATS_EN is set.
module tb_nm_row_compressor;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fails;
   int   cyc;
   int   exp_row;
   int   exp_reg;
   int   last_acc;

   nm_row_compressor_if #(.COLS(64), .BW(8), .ROWS(16), .REGS(8)) bus ();

   nm_row_compressor #(.COLS(64), .BW(8), .ROWS(16), .REGS(8), .GPC(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [511:0] fill(input logic [31:0] grp);
      return {16{grp}};
   endfunction

   // Group words are {e3, e2, e1, e0} with e0 in the low byte.
   localparam logic [31:0]  G_BASIC = 32'h0503FB01;   // {1,-5,3,5}
   localparam logic [31:0]  G_MIX   = 32'hFD04FC03;   // {3,-4,4,-3}
   localparam logic [255:0] V_BASIC = {16{16'h05FB}};
   localparam logic [63:0]  M_BASIC = {16{4'hD}};
   localparam logic [255:0] V_MIX   = {16{16'h04FC}};
   localparam logic [63:0]  M_MIX   = {16{4'h9}};
   localparam logic [511:0] R_TIES  = {{14{32'hFF000000}}, 32'h00000000, 32'h007F7F80};
   localparam logic [255:0] V_TIES  = {{14{16'hFF00}}, 16'h0000, 16'h7F80};
   localparam logic [63:0]  M_TIES  = {{14{4'hC}}, 4'h4, 4'h4};

   task automatic wait_ready();
      int k;
      k = 0;
      while (!bus.in_ready && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check("in_ready_wait", bus.in_ready, 1);
   endtask

   task automatic advance_model();
      if (exp_row == 15) begin
         exp_row = 0;
         exp_reg = (exp_reg + 1) % 8;
      end else begin
         exp_row++;
      end
   endtask

   task automatic run_row(input logic [511:0] row, input logic [255:0] ev, input logic [63:0] em,
                          input int ed, input bit chk_period);
      int k;
      wait_ready();
      bus.in_valid = 1'b1;
      bus.in_row   = row;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      if (chk_period) check("period", cyc - last_acc, 6);
      last_acc = cyc;
      k = 0;
      while (!bus.out_valid && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check("latency", k, 4);
      check("out_val", bus.out_val, ev);
      check("out_meta", bus.out_meta, em);
      check("out_row", bus.out_row, exp_row);
      check("out_reg", bus.out_reg, exp_reg);
      check("out_last", bus.out_last, exp_row == 15);
`ifdef NM_DROP_STATS_EN
      check("drop_cnt", bus.drop_cnt, ed);
`else
      if (ed < 0) check("drop_arg", ed, 0);
`endif
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("out_valid_clr", bus.out_valid, 0);
      advance_model();
   endtask

   initial begin
      int  k;
      bit  seen;
      n_checks      = 0;
      n_fails       = 0;
      exp_row       = 0;
      exp_reg       = 0;
      last_acc      = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_row    = '0;
      bus.out_ready = 1'b0;

      // Reset and idle
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         check("rst_in_ready", bus.in_ready, 0);
         check("rst_out_valid", bus.out_valid, 0);
         check("rst_out_val", bus.out_val, 0);
         check("rst_out_meta", bus.out_meta, 0);
         check("rst_out_row", bus.out_row, 0);
         check("rst_out_reg", bus.out_reg, 0);
         check("rst_out_last", bus.out_last, 0);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_in_ready", bus.in_ready, 1);
      check("idle_out_valid", bus.out_valid, 0);

      // Encoding patterns
      run_row(fill(G_BASIC), V_BASIC, M_BASIC, 32, 1'b0);
      run_row(R_TIES, V_TIES, M_TIES, 1, 1'b0);
      run_row(fill(G_MIX), V_MIX, M_MIX, 32, 1'b0);

      // Backpressure: outputs hold and new input is refused
      wait_ready();
      bus.in_valid = 1'b1;
      bus.in_row   = fill(G_BASIC);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      k = 0;
      while (!bus.out_valid && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check("bp_latency", k, 4);
      for (int c = 0; c < 10; c++) begin
         bus.in_valid = 1'b1;
         bus.in_row   = fill(32'h01010101);
         @(posedge clk); #1;
         check("bp_out_valid", bus.out_valid, 1);
         check("bp_in_ready", bus.in_ready, 0);
         check("bp_out_val", bus.out_val, V_BASIC);
         check("bp_out_meta", bus.out_meta, M_BASIC);
         check("bp_out_row", bus.out_row, exp_row);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("bp_release_valid", bus.out_valid, 0);
      check("bp_release_ready", bus.in_ready, 1);
      advance_model();
      run_row(fill(G_MIX), V_MIX, M_MIX, 32, 1'b0);

      // Reset two cycles into COMPRESS
      wait_ready();
      bus.in_valid = 1'b1;
      bus.in_row   = fill(G_MIX);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst_out_row", bus.out_row, 0);
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         seen |= bus.out_valid;
         @(posedge clk); #1;
      end
      check("mid_rst_no_valid", seen, 0);
      exp_row = 0;
      exp_reg = 0;

      // Stream 129 rows through the full register space and back to 0/0
      for (int n = 0; n < 129; n++) begin
         if (n % 2 == 0)
            run_row(fill(G_BASIC), V_BASIC, M_BASIC, 32, n > 0);
         else
            run_row(fill(G_MIX), V_MIX, M_MIX, 32, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
